// File: rtl/fp_mul_pkg.sv
// Shared widths, constants and the S1->S2 bundle for the FP32 multiplier
// normalize/round/pack stage.
package fp_mul_pkg;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int BIAS  = 127;
    localparam int PW    = 2 * (MAN_W + 1);
    localparam int EW    = EXP_W + 2;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    // e is a two's-complement exponent, EW bits wide
    typedef struct packed {
        logic             sign;
        logic [EW-1:0]    e;
        logic [MAN_W-1:0] man;
        logic             g;
        logic             st;
        logic             nan;
        logic             inf;
        logic             zero;
    } s1_t;
endpackage

// File: rtl/fp_mul_round.sv
// Combinational round, mantissa carry, overflow/underflow detect and pack.
// FP_MUL_RNE_EN selects round-to-nearest-even; otherwise results are truncated.
module fp_mul_round
    import fp_mul_pkg::*;
(
    input  s1_t         s1_i,
    output logic [31:0] result_o,
    output logic        ovf_o,
    output logic        unf_o,
    output logic        inexact_o
);
    localparam logic signed [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);

    logic                    inc;
    logic                    carry;
    logic [MAN_W-1:0]        man_r;
    logic signed [EW-1:0]    e_r;

`ifdef FP_MUL_RNE_EN
    assign inc = s1_i.g & (s1_i.st | s1_i.man[0]);
`else
    assign inc = 1'b0;
`endif

    assign {carry, man_r} = {1'b0, s1_i.man} + {{MAN_W{1'b0}}, inc};
    assign e_r = $signed(s1_i.e) + $signed({{(EW-1){1'b0}}, carry});

    always_comb begin
        result_o  = '0;
        ovf_o     = 1'b0;
        unf_o     = 1'b0;
        inexact_o = 1'b0;
        if (s1_i.nan) begin
            result_o = QNAN;
        end else if (s1_i.inf) begin
            result_o = {s1_i.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s1_i.zero) begin
            result_o = {s1_i.sign, {(EXP_W + MAN_W){1'b0}}};
        end else if (e_r >= E_MAX) begin
            result_o  = {s1_i.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            ovf_o     = 1'b1;
            inexact_o = 1'b1;
        end else if (e_r[EW-1] || (e_r == '0)) begin
            // no subnormal output: anything at or below exponent zero flushes
            result_o  = {s1_i.sign, {(EXP_W + MAN_W){1'b0}}};
            unf_o     = 1'b1;
            inexact_o = 1'b1;
        end else begin
            result_o  = {s1_i.sign, e_r[EXP_W-1:0], man_r};
            inexact_o = s1_i.g | s1_i.st;
        end
    end
endmodule

// File: rtl/fp_mul_norm_pack.sv
// Two-stage valid/ready pipeline: S1 normalizes the 1.m x 1.m product, S2 rounds
// and packs via fp_mul_round. Rounding mode set by FP_MUL_RNE_EN (default truncate).
module fp_mul_norm_pack
    import fp_mul_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W:0]   in_exp_sum,
    input  logic [PW-1:0]    in_prod,
    input  logic             in_nan,
    input  logic             in_inf,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_ovf,
    output logic             out_unf,
    output logic             out_inexact
);
    localparam logic [EW-1:0] BIAS_E = EW'(BIAS);

    s1_t         norm;
    s1_t         s1_q, s1_d;
    logic        s1_v_q, s1_v_d;
    logic        s2_v_q, s2_v_d;
    logic        s2_adv;
    logic [31:0] res_q, res_d;
    logic        ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;
    logic [31:0] rnd_result;
    logic        rnd_ovf, rnd_unf, rnd_inx;
    logic        hi;

    assign hi = in_prod[PW-1];

    always_comb begin
        norm      = '0;
        norm.sign = in_sign;
        norm.e    = {1'b0, in_exp_sum} + {{(EW-1){1'b0}}, hi} - BIAS_E;
        norm.man  = hi ? in_prod[PW-2 -: MAN_W] : in_prod[PW-3 -: MAN_W];
        norm.g    = hi ? in_prod[PW-MAN_W-2] : in_prod[PW-MAN_W-3];
        norm.st   = hi ? |in_prod[PW-MAN_W-3:0] : |in_prod[PW-MAN_W-4:0];
        norm.nan  = in_nan;
        norm.inf  = in_inf;
        norm.zero = in_zero;
    end

    fp_mul_round u_round (
        .s1_i      (s1_q),
        .result_o  (rnd_result),
        .ovf_o     (rnd_ovf),
        .unf_o     (rnd_unf),
        .inexact_o (rnd_inx)
    );

    always_comb begin
        s2_adv   = !s2_v_q | out_ready;
        in_ready = !s1_v_q | s2_adv;

        s1_v_d = in_ready ? in_valid : s1_v_q;
        s1_d   = (in_ready && in_valid) ? norm : s1_q;

        s2_v_d = s2_adv ? s1_v_q : s2_v_q;
        res_d  = res_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        inx_d  = inx_q;
        if (s2_adv && s1_v_q) begin
            res_d = rnd_result;
            ovf_d = rnd_ovf;
            unf_d = rnd_unf;
            inx_d = rnd_inx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
            s1_q   <= '0;
            s2_v_q <= 1'b0;
            res_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
            inx_q  <= 1'b0;
        end else begin
            s1_v_q <= s1_v_d;
            s1_q   <= s1_d;
            s2_v_q <= s2_v_d;
            res_q  <= res_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
            inx_q  <= inx_d;
        end
    end

    assign out_valid   = s2_v_q;
    assign out_result  = res_q;
    assign out_ovf     = ovf_q;
    assign out_unf     = unf_q;
    assign out_inexact = inx_q;
endmodule
